// File: rtl/oc8051_cxrom_arb.sv
// oc8051_cxrom_arb: round-robin arbiter between the instruction-fetch and MOVC
// ports sharing one code-ROM cache read channel. Revision 1.0.
`default_nettype none

module oc8051_cxrom_arb #(
  parameter int ROM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifetch_req,
  input  logic [15:0] ifetch_addr,
  output logic        ifetch_ack,
  output logic        ifetch_valid,
  output logic [31:0] ifetch_data,
  input  logic        movc_req,
  input  logic [15:0] movc_addr,
  output logic        movc_ack,
  output logic        movc_valid,
  output logic [31:0] movc_data,
  output logic        rom_rd,
  output logic [15:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       owner_movc;   // owner of the current/last transaction, doubles as last grant
  logic [2:0] cnt;
  logic       grant_fetch;
  logic       grant_movc;

  always_comb begin
    grant_fetch = 1'b0;
    grant_movc  = 1'b0;
    state_nxt   = state;
    // On a tie the port that was not granted last wins.
    if (state == IDLE && !rst) begin
      if (ifetch_req && (!movc_req || owner_movc))
        grant_fetch = 1'b1;
      else if (movc_req)
        grant_movc = 1'b1;
    end
    case (state)
      IDLE:    if (grant_fetch || grant_movc) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == 3'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner_movc  <= 1'b1;
      cnt         <= 3'd0;
      rom_addr    <= 16'd0;
      ifetch_data <= 32'd0;
      movc_data   <= 32'd0;
    end else begin
      state <= state_nxt;
      if (grant_fetch) begin
        rom_addr   <= ifetch_addr;
        owner_movc <= 1'b0;
        cnt        <= 3'(ROM_LAT);
      end else if (grant_movc) begin
        rom_addr   <= movc_addr;
        owner_movc <= 1'b1;
        cnt        <= 3'(ROM_LAT);
      end
      if (state == WAIT) begin
        if (cnt == 3'd1) begin
          if (owner_movc)
            movc_data <= rom_data;
          else
            ifetch_data <= rom_data;
        end else begin
          cnt <= cnt - 3'd1;
        end
      end
    end
  end

  assign ifetch_ack   = grant_fetch;
  assign movc_ack     = grant_movc;
  assign rom_rd       = (state == ISSUE);
  assign busy         = (state != IDLE);
  assign ifetch_valid = (state == RESP) && !owner_movc;
  assign movc_valid   = (state == RESP) && owner_movc;

endmodule

`default_nettype wire

// File: tb/tb_oc8051_cxrom_arb.sv
// Scoreboard bench for oc8051_cxrom_arb: one instance at ROM_LAT=1, one at ROM_LAT=4.
`default_nettype none

module tb_oc8051_cxrom_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        f0_req, m0_req, f0_ack, m0_ack, f0_vld, m0_vld, rd0, busy0;
  logic [15:0] f0_addr, m0_addr, ra0;
  logic [31:0] f0_data, m0_data, rdat0;
  logic        f1_req, m1_req, f1_ack, m1_ack, f1_vld, m1_vld, rd1, busy1;
  logic [15:0] f1_addr, m1_addr, ra1;
  logic [31:0] f1_data, m1_data, rdat1;

  oc8051_cxrom_arb #(.ROM_LAT(1)) dut0 (
    .clk(clk), .rst(rst),
    .ifetch_req(f0_req), .ifetch_addr(f0_addr), .ifetch_ack(f0_ack),
    .ifetch_valid(f0_vld), .ifetch_data(f0_data),
    .movc_req(m0_req), .movc_addr(m0_addr), .movc_ack(m0_ack),
    .movc_valid(m0_vld), .movc_data(m0_data),
    .rom_rd(rd0), .rom_addr(ra0), .rom_data(rdat0), .busy(busy0)
  );

  oc8051_cxrom_arb #(.ROM_LAT(4)) dut1 (
    .clk(clk), .rst(rst),
    .ifetch_req(f1_req), .ifetch_addr(f1_addr), .ifetch_ack(f1_ack),
    .ifetch_valid(f1_vld), .ifetch_data(f1_data),
    .movc_req(m1_req), .movc_addr(m1_addr), .movc_ack(m1_ack),
    .movc_valid(m1_vld), .movc_data(m1_data),
    .rom_rd(rd1), .rom_addr(ra1), .rom_data(rdat1), .busy(busy1)
  );

  function automatic logic [31:0] romf(input logic [15:0] a);
    if (a == 16'h0104) return 32'h1122_3344;
    return {~a, a};
  endfunction

  // ROM models: data is only meaningful exactly ROM_LAT cycles after rom_rd.
  logic        p0_v;
  logic [15:0] p0_a;
  logic [3:0]  p1_v;
  logic [15:0] p1_a [4];
  always_ff @(posedge clk) begin
    p0_v    <= rd0;
    p0_a    <= ra0;
    p1_v    <= {p1_v[2:0], rd1};
    p1_a[0] <= ra1;
    p1_a[1] <= p1_a[0];
    p1_a[2] <= p1_a[1];
    p1_a[3] <= p1_a[2];
  end
  assign rdat0 = p0_v    ? romf(p0_a)    : 32'hDEAD_BEEF;
  assign rdat1 = p1_v[3] ? romf(p1_a[3]) : 32'hBAD0_BAD0;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          inst;
    logic        port;   // 1 = movc
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic sb_pop(input int inst, input logic port, input logic [31:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_unexpected_valid", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check("sb_owner", {30'd0, 1'(inst), port}, {30'd0, 1'(e.inst), e.port});
      check("sb_data", data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (f0_ack) sb.push_back('{0, 1'b0, romf(f0_addr)});
      if (m0_ack) sb.push_back('{0, 1'b1, romf(m0_addr)});
      if (f1_ack) sb.push_back('{1, 1'b0, romf(f1_addr)});
      if (m1_ack) sb.push_back('{1, 1'b1, romf(m1_addr)});
      if (f0_vld) sb_pop(0, 1'b0, f0_data);
      if (m0_vld) sb_pop(0, 1'b1, m0_data);
      if (f1_vld) sb_pop(1, 1'b0, f1_data);
      if (m1_vld) sb_pop(1, 1'b1, m1_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic wait_idle(input int k);
    int i;
    for (i = 0; i < 30; i++) begin
      samp();
      if (k == 0 && !busy0) break;
      if (k == 1 && !busy1) break;
    end
    check("idle_timeout", 32'(i < 30), 32'd1);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nack, last_cyc, cycn, bad_ack, bad_rd;
    logic exp_port;

    f0_req = 0; m0_req = 0; f1_req = 0; m1_req = 0;
    f0_addr = 16'h1000; m0_addr = 16'h2000; f1_addr = 0; m1_addr = 0;
    f0_req = 1; m0_req = 1;           // held through reset: must not be acked
    repeat (3) cyc();
    samp();
    check("rst_ack_f0", 32'(f0_ack), 0);
    check("rst_ack_m0", 32'(m0_ack), 0);
    check("rst_busy0", 32'(busy0), 0);
    check("rst_rd0", 32'(rd0), 0);
    check("rst_ra0", 32'(ra0), 0);
    check("rst_fdata0", f0_data, 0);
    check("rst_mdata0", m0_data, 0);
    check("rst_vld0", 32'({f0_vld, m0_vld}), 0);
    check("rst_busy1", 32'(busy1), 0);
    check("rst_fdata1", f1_data, 0);

    // Both ports held from reset release: fetch first, then strict alternation.
    cyc();
    rst = 0;
    nack = 0; last_cyc = 0; cycn = 0; exp_port = 1'b0;
    while (nack < 20 && cycn < 200) begin
      samp();
      cycn++;
      if (f0_ack || m0_ack) begin
        check("alt_one_ack", 32'(f0_ack && m0_ack), 0);
        check("alt_owner", 32'(m0_ack), 32'(exp_port));
        if (nack == 0) check("alt_first_ack_cycle", 32'(cycn), 1);
        else           check("alt_ack_gap", 32'(cycn - last_cyc), 4);
        exp_port = ~exp_port;
        last_cyc = cycn;
        nack++;
      end
      cyc();
    end
    check("alt_count", 32'(nack), 20);
    f0_req = 0; m0_req = 0;
    wait_idle(0);

    // Single fetch, ROM_LAT=1.
    f0_addr = 16'h0104; f0_req = 1;
    samp();
    check("b_ack", 32'(f0_ack), 1);
    check("b_mack", 32'(m0_ack), 0);
    cyc(); f0_req = 0;
    samp();
    check("b_rd", 32'(rd0), 1);
    check("b_ra", 32'(ra0), 32'h0104);
    cyc(); samp();
    check("b_rd_low", 32'(rd0), 0);
    check("b_vld_early", 32'(f0_vld), 0);
    cyc(); samp();
    check("b_vld", 32'(f0_vld), 1);
    check("b_data", f0_data, 32'h1122_3344);
    check("b_mvld", 32'(m0_vld), 0);
    check("b_mdata_held", m0_data, romf(16'h2000));
    check("b_ra_held", 32'(ra0), 32'h0104);
    cyc(); samp();
    check("b_vld_pulse", 32'(f0_vld), 0);
    check("b_data_held", f0_data, 32'h1122_3344);
    check("b_idle", 32'(busy0), 0);
    cyc();

    // Fetch pulsed for one cycle while busy: never acked, never read.
    m0_addr = 16'h3000; m0_req = 1;
    samp();
    check("d_mack", 32'(m0_ack), 1);
    cyc(); m0_req = 0; f0_addr = 16'h0BAD; f0_req = 1;
    samp();
    check("d_busy_ack", 32'(f0_ack), 0);
    cyc(); f0_req = 0;
    bad_ack = 0; bad_rd = 0;
    for (int i = 0; i < 8; i++) begin
      samp();
      if (f0_ack) bad_ack++;
      if (rd0 && ra0 == 16'h0BAD) bad_rd++;
      cyc();
    end
    check("d_no_ack", 32'(bad_ack), 0);
    check("d_no_rd", 32'(bad_rd), 0);
    check("d_mdata", m0_data, romf(16'h3000));

    // ROM_LAT=4 movc.
    f1_addr = 16'h0055; f1_req = 1;
    samp();
    check("e_fack", 32'(f1_ack), 1);
    cyc(); f1_req = 0;
    wait_idle(1);
    m1_addr = 16'hFFFE; m1_req = 1;
    samp();
    check("e_mack", 32'(m1_ack), 1);
    cyc(); m1_req = 0;
    samp();
    check("e_rd", 32'(rd1), 1);
    check("e_ra", 32'(ra1), 32'hFFFE);
    for (int k = 2; k <= 5; k++) begin
      cyc(); samp();
      check("e_vld_early", 32'(m1_vld), 0);
    end
    cyc(); samp();
    check("e_vld", 32'(m1_vld), 1);
    check("e_data", m1_data, 32'h0001_FFFE);
    check("e_fdata_held", f1_data, romf(16'h0055));
    check("e_fvld", 32'(f1_vld), 0);
    cyc(); samp();
    check("e_idle", 32'(busy1), 0);
    cyc();

    // Reset in the WAIT cycle aborts the transaction.
    f0_addr = 16'h0200; f0_req = 1;
    samp();
    check("f_ack", 32'(f0_ack), 1);
    cyc(); f0_req = 0;
    samp();
    cyc();
    rst = 1; f0_addr = 16'h0300; f0_req = 1;
    samp();
    check("f_ack_in_rst", 32'(f0_ack), 0);
    cyc(); rst = 0;
    samp();
    check("f_no_vld", 32'(f0_vld), 0);
    check("f_busy", 32'(busy0), 0);
    check("f_rd", 32'(rd0), 0);
    check("f_ra", 32'(ra0), 0);
    check("f_fdata", f0_data, 0);
    check("f_mdata", m0_data, 0);
    check("f_ack_after", 32'(f0_ack), 1);
    cyc(); f0_req = 0;
    wait_idle(0);
    check("f_new_data", f0_data, romf(16'h0300));

    repeat (3) cyc();
    check("sb_drain", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
